// File: rtl/value_buffer_alloc_if.sv
// Dispatch-side handshake between the dispatch stage and the value buffer
// allocator: per-slot requests with branch masks in, granted pointers out.
interface value_buffer_alloc_if #(
    parameter int BUFFER_SEL  = 5,
    parameter int SPECTAG_LEN = 5
);
    logic                   req_1;
    logic                   req_2;
    logic [SPECTAG_LEN-1:0] spectag_1;
    logic [SPECTAG_LEN-1:0] spectag_2;
    logic [BUFFER_SEL-1:0]  ptr_1;
    logic [BUFFER_SEL-1:0]  ptr_2;
    logic                   invalid1;
    logic                   invalid2;
    logic                   alloc_stall;

    modport master (
        output req_1, req_2, spectag_1, spectag_2,
        input  ptr_1, ptr_2, invalid1, invalid2, alloc_stall
    );

    modport slave (
        input  req_1, req_2, spectag_1, spectag_2,
        output ptr_1, ptr_2, invalid1, invalid2, alloc_stall
    );
endinterface

// File: rtl/value_buffer_alloc.sv
// Value buffer entry allocator. Grants up to two free entries per cycle to
// dispatch (all-or-nothing), reclaims entries on issue, and squashes entries
// tagged with a mispredicted branch in a single cycle.
// Optional self-check: define VB_ALLOC_CHECK_EN to enable the sticky
// alloc_err_o flag (issue to a non-busy entry, free-count inconsistency).
module value_buffer_alloc #(
    parameter int BUFFER_NUM  = 32,
    parameter int BUFFER_SEL  = 5,
    parameter int SPECTAG_LEN = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    value_buffer_alloc_if.slave    disp,
    input  logic                   issued_1_i,
    input  logic                   issued_2_i,
    input  logic                   issued_3_i,
    input  logic [BUFFER_SEL-1:0]  issue_ptr_1_i,
    input  logic [BUFFER_SEL-1:0]  issue_ptr_2_i,
    input  logic [BUFFER_SEL-1:0]  issue_ptr_3_i,
    input  logic                   prmiss_i,
    input  logic                   prsuccess_i,
    input  logic [SPECTAG_LEN-1:0] prtag_i,
    output logic [BUFFER_SEL:0]    free_count_o,
    output logic                   alloc_err_o
);

    logic [BUFFER_NUM-1:0]  busy_q;
    logic [BUFFER_NUM-1:0]  busy_d;
    logic [SPECTAG_LEN-1:0] depmask_q [BUFFER_NUM];
    logic [SPECTAG_LEN-1:0] depmask_d [BUFFER_NUM];
    logic [BUFFER_SEL:0]    free_count_q;
    logic [BUFFER_SEL:0]    free_count_d;

    logic [BUFFER_SEL-1:0]  f0;
    logic [BUFFER_SEL-1:0]  f1;
    logic                   f0_found;
    logic                   f1_found;

    logic                   stall;
    logic                   grant_1;
    logic                   grant_2;
    logic [BUFFER_SEL-1:0]  gptr_1;
    logic [BUFFER_SEL-1:0]  gptr_2;
    logic [BUFFER_SEL:0]    req_cnt;
    logic [BUFFER_SEL:0]    grant_cnt;
    logic [BUFFER_SEL:0]    freed_cnt;
    logic [BUFFER_NUM-1:0]  free_vec;
    logic [SPECTAG_LEN-1:0] succ_clr;

    function automatic logic [BUFFER_SEL:0] popcount(input logic [BUFFER_NUM-1:0] v);
        logic [BUFFER_SEL:0] cnt;
        cnt = '0;
        for (int i = 0; i < BUFFER_NUM; i++) begin
            cnt = cnt + {{BUFFER_SEL{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Priority search for the two lowest-index free entries.
    always_comb begin
        f0       = '0;
        f1       = '0;
        f0_found = 1'b0;
        f1_found = 1'b0;
        for (int i = 0; i < BUFFER_NUM; i++) begin
            if (!busy_q[i]) begin
                if (!f0_found) begin
                    f0       = BUFFER_SEL'(i);
                    f0_found = 1'b1;
                end else if (!f1_found) begin
                    f1       = BUFFER_SEL'(i);
                    f1_found = 1'b1;
                end
            end
        end
    end

    // All-or-nothing grant decision; a misprediction or reset blocks dispatch.
    always_comb begin
        req_cnt   = {{BUFFER_SEL{1'b0}}, disp.req_1} + {{BUFFER_SEL{1'b0}}, disp.req_2};
        stall     = ~reset_i | (req_cnt > free_count_q) | prmiss_i;
        grant_1   = disp.req_1 & ~stall;
        grant_2   = disp.req_2 & ~stall;
        gptr_1    = grant_1 ? f0 : '0;
        gptr_2    = grant_2 ? (disp.req_1 ? f1 : f0) : '0;
        grant_cnt = {{BUFFER_SEL{1'b0}}, grant_1} + {{BUFFER_SEL{1'b0}}, grant_2};
    end

    assign disp.ptr_1       = gptr_1;
    assign disp.ptr_2       = gptr_2;
    assign disp.invalid1    = ~grant_1;
    assign disp.invalid2    = ~grant_2;
    assign disp.alloc_stall = stall;
    assign free_count_o     = free_count_q;

    // Entries leaving the busy set: issue frees (only of busy entries, so
    // duplicate pointers collapse) unioned with the misprediction squash.
    always_comb begin
        free_vec = '0;
        if (issued_1_i && busy_q[issue_ptr_1_i]) free_vec[issue_ptr_1_i] = 1'b1;
        if (issued_2_i && busy_q[issue_ptr_2_i]) free_vec[issue_ptr_2_i] = 1'b1;
        if (issued_3_i && busy_q[issue_ptr_3_i]) free_vec[issue_ptr_3_i] = 1'b1;
        if (prmiss_i) begin
            for (int i = 0; i < BUFFER_NUM; i++) begin
                if (busy_q[i] && ((depmask_q[i] & prtag_i) != '0)) free_vec[i] = 1'b1;
            end
        end
        freed_cnt = popcount(free_vec);
    end

    // Next busy set, dependency masks and free count. Grants only target
    // entries that are free now, so they never collide with this cycle's frees.
    always_comb begin
        succ_clr = prsuccess_i ? prtag_i : '0;
        busy_d   = busy_q & ~free_vec;
        for (int i = 0; i < BUFFER_NUM; i++) begin
            depmask_d[i] = free_vec[i] ? '0 : (depmask_q[i] & ~succ_clr);
        end
        if (grant_1) begin
            busy_d[gptr_1]    = 1'b1;
            depmask_d[gptr_1] = disp.spectag_1 & ~succ_clr;
        end
        if (grant_2) begin
            busy_d[gptr_2]    = 1'b1;
            depmask_d[gptr_2] = disp.spectag_2 & ~succ_clr;
        end
        free_count_d = free_count_q - grant_cnt + freed_cnt;
    end

    // Allocator state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            busy_q       <= '0;
            free_count_q <= (BUFFER_SEL+1)'(BUFFER_NUM);
            for (int i = 0; i < BUFFER_NUM; i++) depmask_q[i] <= '0;
        end else begin
            busy_q       <= busy_d;
            free_count_q <= free_count_d;
            for (int i = 0; i < BUFFER_NUM; i++) depmask_q[i] <= depmask_d[i];
        end
    end

`ifdef VB_ALLOC_CHECK_EN
    logic alloc_err_q;
    logic bad_issue;
    logic count_bad;

    // Flag frees aimed at idle entries and drift between the counter and busy set.
    always_comb begin
        bad_issue = (issued_1_i & ~busy_q[issue_ptr_1_i]) |
                    (issued_2_i & ~busy_q[issue_ptr_2_i]) |
                    (issued_3_i & ~busy_q[issue_ptr_3_i]);
        count_bad = (free_count_q != popcount(~busy_q));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            alloc_err_q <= 1'b0;
        end else if (bad_issue || count_bad) begin
            alloc_err_q <= 1'b1;
`ifndef SYNTHESIS
            if (!alloc_err_q) $display("value_buffer_alloc: alloc_err set (bad_issue=%0b count_bad=%0b)", bad_issue, count_bad);
`endif
        end
    end

    assign alloc_err_o = alloc_err_q;
`else
    assign alloc_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_value_buffer_alloc.sv
// Directed bench for value_buffer_alloc with hand-computed expectations.
module tb_value_buffer_alloc;
    localparam int BN = 32;
    localparam int BS = 5;
    localparam int ST = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          issued_1_i, issued_2_i, issued_3_i;
    logic [BS-1:0] issue_ptr_1_i, issue_ptr_2_i, issue_ptr_3_i;
    logic          prmiss_i, prsuccess_i;
    logic [ST-1:0] prtag_i;
    logic [BS:0]   free_count_o;
    logic          alloc_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    value_buffer_alloc_if #(.BUFFER_SEL(BS), .SPECTAG_LEN(ST)) vif ();

    value_buffer_alloc #(.BUFFER_NUM(BN), .BUFFER_SEL(BS), .SPECTAG_LEN(ST)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .disp          (vif),
        .issued_1_i    (issued_1_i),
        .issued_2_i    (issued_2_i),
        .issued_3_i    (issued_3_i),
        .issue_ptr_1_i (issue_ptr_1_i),
        .issue_ptr_2_i (issue_ptr_2_i),
        .issue_ptr_3_i (issue_ptr_3_i),
        .prmiss_i      (prmiss_i),
        .prsuccess_i   (prsuccess_i),
        .prtag_i       (prtag_i),
        .free_count_o  (free_count_o),
        .alloc_err_o   (alloc_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        vif.req_1 = 1'b0; vif.req_2 = 1'b0;
        vif.spectag_1 = '0; vif.spectag_2 = '0;
        issued_1_i = 1'b0; issued_2_i = 1'b0; issued_3_i = 1'b0;
        issue_ptr_1_i = '0; issue_ptr_2_i = '0; issue_ptr_3_i = '0;
        prmiss_i = 1'b0; prsuccess_i = 1'b0; prtag_i = '0;
    endtask

    initial begin
        idle();
        reset_i = 1'b0;
        vif.req_1 = 1'b1; vif.req_2 = 1'b1;
        tick();
        #1;
        chk("rst_invalid1", 32'(vif.invalid1), 1);
        chk("rst_invalid2", 32'(vif.invalid2), 1);
        chk("rst_stall", 32'(vif.alloc_stall), 1);
        tick();
        chk("rst_free_count", 32'(free_count_o), 32);
        chk("rst_alloc_err", 32'(alloc_err_o), 0);

        // First dual grant after reset.
        reset_i = 1'b1;
        #1;
        chk("g0_ptr_1", 32'(vif.ptr_1), 0);
        chk("g0_ptr_2", 32'(vif.ptr_2), 1);
        chk("g0_invalid1", 32'(vif.invalid1), 0);
        chk("g0_invalid2", 32'(vif.invalid2), 0);
        chk("g0_stall", 32'(vif.alloc_stall), 0);
        tick();
        chk("g0_free_count", 32'(free_count_o), 30);

        // Fill entries 2..31; entries 2,3 tagged 00010, 4 untagged, 5 tagged 00100.
        for (int i = 0; i < 15; i++) begin
            vif.spectag_1 = (i == 0) ? 5'b00010 : 5'b00000;
            vif.spectag_2 = (i == 0) ? 5'b00010 : ((i == 1) ? 5'b00100 : 5'b00000);
            #1;
            chk("fill_ptr_1", 32'(vif.ptr_1), 32'(2 + 2 * i));
            chk("fill_ptr_2", 32'(vif.ptr_2), 32'(3 + 2 * i));
            tick();
        end
        idle();
        chk("full_free_count", 32'(free_count_o), 0);

        // Full: request stalls; the same-cycle issue free is not bypassed.
        vif.req_1 = 1'b1;
        issued_1_i = 1'b1; issue_ptr_1_i = 5'd7;
        #1;
        chk("full_stall", 32'(vif.alloc_stall), 1);
        chk("full_invalid1", 32'(vif.invalid1), 1);
        tick();
        issued_1_i = 1'b0;
        chk("free7_free_count", 32'(free_count_o), 1);
        #1;
        chk("regrant7_ptr_1", 32'(vif.ptr_1), 7);
        chk("regrant7_invalid1", 32'(vif.invalid1), 0);
        tick();
        idle();
        chk("regrant7_free_count", 32'(free_count_o), 0);

        // One free entry with two requests: no partial grant.
        issued_1_i = 1'b1; issue_ptr_1_i = 5'd7;
        tick();
        idle();
        vif.req_1 = 1'b1; vif.req_2 = 1'b1;
        #1;
        chk("one_free_stall", 32'(vif.alloc_stall), 1);
        chk("one_free_invalid1", 32'(vif.invalid1), 1);
        chk("one_free_invalid2", 32'(vif.invalid2), 1);
        chk("one_free_ptr_1", 32'(vif.ptr_1), 0);
        tick();
        idle();
        chk("one_free_count", 32'(free_count_o), 1);

        // Misprediction on tag 00010 squashes entries 2 and 3 only.
        vif.req_1 = 1'b1;
        prmiss_i = 1'b1; prtag_i = 5'b00010;
        #1;
        chk("miss_stall", 32'(vif.alloc_stall), 1);
        chk("miss_invalid1", 32'(vif.invalid1), 1);
        chk("miss_invalid2", 32'(vif.invalid2), 1);
        tick();
        idle();
        chk("miss_free_count", 32'(free_count_o), 3);
        vif.req_1 = 1'b1; vif.req_2 = 1'b1;
        #1;
        chk("post_miss_ptr_1", 32'(vif.ptr_1), 2);
        chk("post_miss_ptr_2", 32'(vif.ptr_2), 3);
        tick();
        idle();
        vif.req_1 = 1'b1;
        #1;
        chk("entry4_busy_ptr_1", 32'(vif.ptr_1), 7);
        tick();
        idle();
        chk("refill_free_count", 32'(free_count_o), 0);

        // Correct resolution of tag 00100 protects entry 5 from a later miss.
        prsuccess_i = 1'b1; prtag_i = 5'b00100;
        tick();
        idle();
        prmiss_i = 1'b1; prtag_i = 5'b00100;
        #1;
        chk("miss_noreq_stall", 32'(vif.alloc_stall), 1);
        tick();
        idle();
        chk("entry5_kept_free_count", 32'(free_count_o), 0);

        // Duplicate issue pointers count once.
        issued_1_i = 1'b1; issue_ptr_1_i = 5'd9;
        issued_2_i = 1'b1; issue_ptr_2_i = 5'd9;
        tick();
        idle();
        chk("dup_issue_free_count", 32'(free_count_o), 1);
        vif.req_2 = 1'b1;
        #1;
        chk("slot2_ptr_2", 32'(vif.ptr_2), 9);
        chk("slot2_ptr_1", 32'(vif.ptr_1), 0);
        chk("slot2_invalid1", 32'(vif.invalid1), 1);
        chk("slot2_invalid2", 32'(vif.invalid2), 0);
        tick();
        idle();
        chk("slot2_free_count", 32'(free_count_o), 0);

        // Three issue ports, two distinct entries.
        issued_1_i = 1'b1; issue_ptr_1_i = 5'd10;
        issued_2_i = 1'b1; issue_ptr_2_i = 5'd11;
        issued_3_i = 1'b1; issue_ptr_3_i = 5'd10;
        tick();
        idle();
        chk("tri_issue_free_count", 32'(free_count_o), 2);
        vif.req_1 = 1'b1; vif.req_2 = 1'b1;
        #1;
        chk("tri_ptr_1", 32'(vif.ptr_1), 10);
        chk("tri_ptr_2", 32'(vif.ptr_2), 11);
        tick();
        idle();

        // Issue to an entry that is already free is ignored.
        issued_1_i = 1'b1; issue_ptr_1_i = 5'd12;
        tick();
        chk("free12_count", 32'(free_count_o), 1);
        tick();
        idle();
        chk("stale_issue_count", 32'(free_count_o), 1);
`ifdef VB_ALLOC_CHECK_EN
        chk("alloc_err_set", 32'(alloc_err_o), 1);
`else
        chk("alloc_err_tied", 32'(alloc_err_o), 0);
`endif

        // Re-allocate 12 with tag 01000, then squash it alongside an issue free.
        vif.req_1 = 1'b1; vif.spectag_1 = 5'b01000;
        #1;
        chk("alloc12_ptr_1", 32'(vif.ptr_1), 12);
        tick();
        idle();
        prmiss_i = 1'b1; prtag_i = 5'b01000;
        issued_1_i = 1'b1; issue_ptr_1_i = 5'd13;
        tick();
        idle();
        chk("union_free_count", 32'(free_count_o), 2);
        vif.req_1 = 1'b1; vif.req_2 = 1'b1;
        #1;
        chk("union_ptr_1", 32'(vif.ptr_1), 12);
        chk("union_ptr_2", 32'(vif.ptr_2), 13);
        tick();
        idle();
        chk("final_free_count", 32'(free_count_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/value_buffer_alloc.md
Name: value_buffer_alloc

Overview:
- Dispatch-side allocator for the immediate/PC value buffer; sits directly upstream of value_buffer.
- Tracks busy entries, grants up to two entry pointers per cycle to dispatch (drives value_buffer ptr_1/ptr_2/invalid1/invalid2) and reclaims entries when their consumers issue.
- Per-entry branch dependency masks let a misprediction reclaim squashed entries in one cycle.

Parameters:
- BUFFER_NUM, 32, number of value buffer entries
- BUFFER_SEL, 5, pointer width, log2(BUFFER_NUM)
- SPECTAG_LEN, 5, number of in-flight branch tags, one-hot

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-low; state clears on the posedge where reset==0
- req_1  in  1  dispatch slot 1 needs a value entry
- req_2  in  1  dispatch slot 2 needs a value entry
- spectag_1  in  SPECTAG_LEN  branch dependency mask of slot 1
- spectag_2  in  SPECTAG_LEN  branch dependency mask of slot 2
- ptr_1  out  BUFFER_SEL  granted entry, slot 1
- ptr_2  out  BUFFER_SEL  granted entry, slot 2
- invalid1  out  1  1 = no entry granted to slot 1
- invalid2  out  1  1 = no entry granted to slot 2
- alloc_stall  out  1  requests cannot all be granted this cycle
- issued_1/2/3  in  1 each  consumer of an entry issued
- issue_ptr_1/2/3  in  BUFFER_SEL each  entry freed by that issue
- prmiss  in  1  branch misprediction
- prsuccess  in  1  branch resolved correctly
- prtag  in  SPECTAG_LEN  one-hot tag of the resolving branch
- free_count  out  BUFFER_SEL+1  registered number of free entries
- alloc_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- State: busy[BUFFER_NUM], depmask[BUFFER_NUM][SPECTAG_LEN], free_count register.
- Reset (reset==0 at posedge): busy=0, depmask=0, free_count=BUFFER_NUM, alloc_err=0. While reset==0: invalid1=invalid2=1, alloc_stall=1, no state updates.
- Grant (combinational from current busy):
  - f0 = lowest-index free entry; f1 = second-lowest.
  - req_1&req_2: ptr_1=f0, ptr_2=f1.
  - Only req_1: ptr_1=f0. Only req_2: ptr_2=f0.
  - Ungranted ptr outputs = 0.
- All-or-nothing: alloc_stall = (req_1+req_2 > free_count) | prmiss. When alloc_stall=1, both invalids=1 and no grant occurs.
- invalidN = ~(req_N & ~alloc_stall).
- Posedge, on a grant: busy[ptr]<=1; depmask[ptr]<=spectag_N, with the prtag bit cleared if prsuccess is high in the same cycle.
- Issue free: for each k, if issued_k & busy[issue_ptr_k], then busy<=0 and depmask<=0 at the next posedge.
  - Duplicate issue_ptr values across ports count once.
  - Frees are visible to grant logic only from the following cycle; no same-cycle bypass.
- prsuccess: clear the prtag bit in depmask of every entry.
- prmiss: free every busy entry with (depmask & prtag)!=0. No grant that cycle.
- prmiss, prsuccess and issue frees in the same cycle: the resulting free set is their union.
- free_count_next = free_count − grants + number of distinct entries transitioning busy→free. It must always equal the popcount of ~busy.
- Full: free_count==0 → any request stalls.
- One entry free with req_1&req_2 → stall, no partial grant.
- Issue free of an entry that is not busy → ignored; no count change.

Optional Feature:
- Macro: VB_ALLOC_CHECK_EN.
- Defined:
  - alloc_err sets (sticky until reset) on an issue free of a non-busy entry.
  - alloc_err also sets if free_count != popcount(~busy) after any update.
  - Simulation $display is emitted on set.
- Undefined: checking logic is absent and alloc_err is tied 0.

Test Plan:
- Reset then req_1=req_2=1 → ptr_1=0, ptr_2=1, invalids 0; next cycle free_count=30.
- Allocate all 32 entries, then req_1=1 → alloc_stall=1, invalid1=1; issued_1 with ptr 7 → next cycle req_1 grants ptr_1=7, free_count 0.
- free_count=1, req_1=req_2=1 → alloc_stall=1, no grant, free_count stays 1.
- Entries 2,3 allocated with spectag 00010, entry 4 with 00000; prmiss with prtag=00010 → entries 2,3 freed, 4 busy; that cycle invalids=1.
- Entry 5 allocated with spectag 00100; prsuccess prtag=00100 → depmask[5]=0; later prmiss prtag=00100 leaves entry 5 busy.
- issued_1 and issued_2 both ptr 9 (busy) → free_count rises by 1; with VB_ALLOC_CHECK_EN, issue to free entry 9 again → alloc_err=1.
